// File: rtl/cic_decimator_if.sv
// Sample/rate bus between the integrator chain, the decimator and the
// first comb stage.
interface cic_decimator_if #(
    parameter int SAMP_WIDTH = 8,
    parameter int RATE_WIDTH = 8
);
    logic signed [SAMP_WIDTH-1:0] samp_inp_data;
    logic                         samp_inp_str;
    logic        [RATE_WIDTH-1:0] rate_val;
    logic                         rate_load;
    logic                         phase_sync;
    logic signed [SAMP_WIDTH-1:0] samp_out_data;
    logic                         samp_out_str;
    logic        [RATE_WIDTH-1:0] rate_active;
    logic                         rate_err;

    modport master (
        output samp_inp_data, samp_inp_str, rate_val, rate_load, phase_sync,
        input  samp_out_data, samp_out_str, rate_active, rate_err
    );

    modport slave (
        input  samp_inp_data, samp_inp_str, rate_val, rate_load, phase_sync,
        output samp_out_data, samp_out_str, rate_active, rate_err
    );
endinterface

// File: rtl/cic_decimator.sv
// CIC decimation stage: keeps every R-th integrator sample, with a
// reloadable ratio that takes effect on a block boundary or phase sync.
module cic_decimator #(
    parameter int SAMP_WIDTH   = 8,
    parameter int RATE_WIDTH   = 8,
    parameter int DEFAULT_RATE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    cic_decimator_if.slave  bus
);
    logic        [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic        [RATE_WIDTH-1:0] rate_cur_q, rate_cur_d;
    logic        [RATE_WIDTH-1:0] rate_pend_q, rate_pend_d;
    logic                         pend_valid_q, pend_valid_d;
    logic                         rate_err_q, rate_err_d;
    logic signed [SAMP_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_str_q, out_str_d;

    logic                  good_load;
    logic                  zero_load;
    logic                  boundary;
    logic [RATE_WIDTH-1:0] rate_next;

    assign good_load = bus.rate_load && (bus.rate_val != '0);
    assign zero_load = bus.rate_load && (bus.rate_val == '0);
    assign boundary  = bus.samp_inp_str &&
                       (cnt_q == rate_cur_q - RATE_WIDTH'(1));

    // Ratio to adopt when a block restarts: a same-cycle load beats a pending one.
    assign rate_next = good_load    ? bus.rate_val :
                       pend_valid_q ? rate_pend_q  : rate_cur_q;

    always_comb begin
        cnt_d        = cnt_q;
        rate_cur_d   = rate_cur_q;
        rate_pend_d  = rate_pend_q;
        pend_valid_d = pend_valid_q;
        rate_err_d   = rate_err_q | zero_load;
        out_data_d   = out_data_q;
        out_str_d    = 1'b0;

        if (bus.phase_sync) begin
            rate_cur_d   = rate_next;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
            if (bus.samp_inp_str) begin
                if (rate_next == RATE_WIDTH'(1)) begin
                    out_data_d = bus.samp_inp_data;
                    out_str_d  = 1'b1;
                end else begin
                    cnt_d = RATE_WIDTH'(1);
                end
            end
        end else if (boundary) begin
            out_data_d   = bus.samp_inp_data;
            out_str_d    = 1'b1;
            cnt_d        = '0;
            rate_cur_d   = rate_next;
            pend_valid_d = 1'b0;
        end else begin
            if (bus.samp_inp_str) begin
                cnt_d = cnt_q + RATE_WIDTH'(1);
            end
            if (good_load) begin
                rate_pend_d  = bus.rate_val;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            rate_cur_q   <= RATE_WIDTH'(DEFAULT_RATE);
            rate_pend_q  <= '0;
            pend_valid_q <= 1'b0;
            rate_err_q   <= 1'b0;
            out_data_q   <= '0;
            out_str_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rate_cur_q   <= rate_cur_d;
            rate_pend_q  <= rate_pend_d;
            pend_valid_q <= pend_valid_d;
            rate_err_q   <= rate_err_d;
            out_data_q   <= out_data_d;
            out_str_q    <= out_str_d;
        end
    end

    assign bus.samp_out_data = out_data_q;
    assign bus.samp_out_str  = out_str_q;
    assign bus.rate_active   = rate_cur_q;
    assign bus.rate_err      = rate_err_q;
endmodule

// File: tb/tb_cic_decimator.sv
// Randomised scoreboard bench for cic_decimator against a sample-counting
// reference model of the decimator.
module tb_cic_decimator;
    localparam int SW = 8;
    localparam int RW = 8;
    localparam int DR = 4;

    logic clk;
    logic reset_n;

    cic_decimator_if #(.SAMP_WIDTH(SW), .RATE_WIDTH(RW)) bus ();

    cic_decimator #(
        .SAMP_WIDTH(SW), .RATE_WIDTH(RW), .DEFAULT_RATE(DR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_out = 0;
    bit started = 1'b0;

    logic signed [SW-1:0] exp_q[$];

    // Reference model: samples taken in the current block, ratio in force.
    int m_rate, m_pend, m_taken;
    bit m_pv, m_err, m_str;
    logic signed [SW-1:0] m_last;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_rate = DR; m_pend = 0; m_taken = 0;
        m_pv = 0; m_err = 0; m_str = 0; m_last = '0;
    endtask

    task automatic take(input logic signed [SW-1:0] d);
        m_taken = m_taken + 1;
        if (m_taken == m_rate) begin
            m_taken = 0;
            m_str = 1;
            m_last = d;
            exp_q.push_back(d);
        end
    endtask

    task automatic step(input bit rst, input bit str,
                        input logic signed [SW-1:0] d, input bit ld,
                        input int rv, input bit sy);
        bit emitted;
        reset_n = !rst;
        bus.samp_inp_str = str;
        bus.samp_inp_data = d;
        bus.rate_load = ld;
        bus.rate_val = RW'(rv);
        bus.phase_sync = sy;
        @(posedge clk);
        started = 1'b1;
        m_str = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (ld && rv == 0) m_err = 1;
            if (sy) begin
                if (ld && rv != 0) m_rate = rv;
                else if (m_pv) m_rate = m_pend;
                m_pv = 0;
                m_taken = 0;
                if (str) take(d);
            end else begin
                emitted = 0;
                if (str) begin
                    take(d);
                    emitted = m_str;
                end
                if (emitted) begin
                    if (ld && rv != 0) m_rate = rv;
                    else if (m_pv) m_rate = m_pend;
                    m_pv = 0;
                end else if (ld && rv != 0) begin
                    m_pend = rv;
                    m_pv = 1;
                end
            end
        end
        #1;
        reset_n = 1'b1;
        bus.samp_inp_str = 1'b0;
        bus.rate_load = 1'b0;
        bus.phase_sync = 1'b0;
    endtask

    task automatic strobe(input int d);
        step(0, 1, SW'(d), 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("rate_active", 32'(bus.rate_active), 32'(m_rate));
            chk("rate_err", 32'(bus.rate_err), 32'(m_err));
            chk("out_str", 32'(bus.samp_out_str), 32'(m_str));
            chk("out_data", 32'(bus.samp_out_data), 32'(m_last));
            if (bus.samp_out_str === 1'b1) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.samp_out_data), 32'hdead);
                end else begin
                    chk("sb_data", 32'(bus.samp_out_data),
                        32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int base;
        reset_n = 1'b0;
        bus.samp_inp_str = 1'b0;
        bus.samp_inp_data = '0;
        bus.rate_load = 1'b0;
        bus.rate_val = '0;
        bus.phase_sync = 1'b0;
        model_reset();
        step(1, 1, 8'sd7, 1, 3, 1);
        step(1, 0, '0, 0, 0, 0);
        @(negedge clk);
        chk("reset_data", 32'(bus.samp_out_data), 32'd0);
        chk("reset_rate", 32'(bus.rate_active), 32'(DR));

        // R=4 continuous 1..12
        base = n_out;
        for (int i = 1; i <= 12; i++) strobe(i);
        idle();
        @(negedge clk);
        chk("cont_outs", 32'(n_out - base), 32'd3);
        chk("cont_hold", 32'(bus.samp_out_data), 32'd12);

        // every 3rd cycle, -5..-12
        for (int i = 5; i <= 12; i++) begin
            strobe(-i);
            if (i == 9) begin
                @(negedge clk);
                chk("neg_hold", 32'(bus.samp_out_data), 32'hfffffff8);
            end
            idle();
            idle();
        end

        // reload R=2 after 2 samples
        step(1, 0, '0, 0, 0, 0);
        base = n_out;
        strobe(1); strobe(2);
        step(0, 0, '0, 1, 2, 0);
        for (int i = 3; i <= 8; i++) strobe(i);
        idle();
        @(negedge clk);
        chk("reload_outs", 32'(n_out - base), 32'd3);
        chk("reload_rate", 32'(bus.rate_active), 32'd2);

        // phase sync with R=4, then R=1
        step(1, 0, '0, 0, 0, 0);
        strobe(1); strobe(2);
        base = n_out;
        step(0, 1, 8'sd50, 0, 0, 1);
        for (int i = 2; i <= 8; i++) strobe(50 + i);
        idle();
        @(negedge clk);
        chk("sync_outs", 32'(n_out - base), 32'd2);
        chk("sync_last", 32'(bus.samp_out_data), 32'd58);
        base = n_out;
        step(0, 1, 8'sd70, 1, 1, 1);
        for (int i = 1; i <= 4; i++) strobe(70 + i);
        idle();
        @(negedge clk);
        chk("r1_outs", 32'(n_out - base), 32'd5);

        // zero load sets sticky error
        step(0, 0, '0, 1, 0, 0);
        @(negedge clk);
        chk("err_set", 32'(bus.rate_err), 32'd1);
        chk("err_rate", 32'(bus.rate_active), 32'd1);
        step(0, 0, '0, 1, 3, 1);
        @(negedge clk);
        chk("err_sticky", 32'(bus.rate_err), 32'd1);

        // mid-block reset
        strobe(1); strobe(2);
        step(1, 1, 8'sd9, 1, 5, 1);
        @(negedge clk);
        chk("rst_err", 32'(bus.rate_err), 32'd0);
        chk("rst_rate", 32'(bus.rate_active), 32'(DR));
        base = n_out;
        for (int i = 1; i <= DR; i++) strobe(i);
        idle();
        @(negedge clk);
        chk("rst_outs", 32'(n_out - base), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 60,
                 SW'($urandom),
                 $urandom_range(0, 99) < 5,
                 int'($urandom_range(0, 6)),
                 $urandom_range(0, 99) < 3);
        end
        idle();
        idle();
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
